// File: rtl/ibex_register_file_wb.sv
// ibex_register_file_wb
// ---------------------------------------------------------------------------
// Flop-based integer register file that sits directly after the writeback
// stage. It accepts one write per cycle and serves two combinational read
// ports to ID/EX. x0 always reads zero. In RV32E builds, a write to an
// unimplemented register (x16..x31) is dropped and raises a sticky error.
//
// Parameters
//   RV32E      1: 16 registers (address bit 4 set = unimplemented); 0: 32
//   DataWidth  register width in bits
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset; clears all state
//   raddr_a_i     read port A address
//   rdata_a_o     read port A data (combinational)
//   raddr_b_i     read port B address
//   rdata_b_o     read port B data (combinational)
//   waddr_a_i     write address (from WB stage)
//   wdata_a_i     write data (from WB stage)
//   we_a_i        write enable (from WB stage)
//   err_clr_i     clears the sticky illegal-write flag
//   illegal_we_o  sticky: a write targeted an unimplemented register
//   wr_count_o    saturating count of committed architectural writes
//
// Configuration macro
//   IBEX_RF_BYPASS_EN  when defined, a committed write is forwarded to any
//                      read port that addresses the same register in the
//                      same cycle. When undefined, reads return the stored
//                      value and the hazard is left to WB forwarding.
// ---------------------------------------------------------------------------
module ibex_register_file_wb #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  input  logic                 err_clr_i,
  output logic                 illegal_we_o,
  output logic [15:0]          wr_count_o
);

  localparam int unsigned NumRegs = RV32E ? 16 : 32;
  localparam int unsigned AddrW   = RV32E ? 4 : 5;

  logic [DataWidth-1:0] rf_q [NumRegs];
  logic                 illegal_q;
  logic [15:0]          wr_count_q;

  logic                 waddr_impl;
  logic                 wr_commit;
  logic                 wr_illegal;
  logic [AddrW-1:0]     widx;

  // An address is implemented unless RV32E is set and bit 4 is high.
  function automatic logic addr_impl(input logic [4:0] addr);
    return RV32E ? ~addr[4] : 1'b1;
  endfunction

  // Bump the write counter, holding at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign waddr_impl = addr_impl(waddr_a_i);
  assign widx       = waddr_a_i[AddrW-1:0];

  // x0 writes are silently discarded: no state change, no error, no count.
  assign wr_commit  = we_a_i & waddr_impl & (waddr_a_i != 5'd0);
  assign wr_illegal = we_a_i & ~waddr_impl;

  // Register storage. Entry 0 is reset and never written, so it reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_commit) begin
      rf_q[widx] <= wdata_a_i;
    end
  end

  // A new illegal write wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else if (wr_illegal) begin
      illegal_q <= 1'b1;
    end else if (err_clr_i) begin
      illegal_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_count_q <= '0;
    end else if (wr_commit) begin
      wr_count_q <= sat_inc(wr_count_q);
    end
  end

  // Stored value for a read address; unimplemented addresses read zero.
  function automatic logic [DataWidth-1:0] rd_stored(input logic [4:0] addr);
    return addr_impl(addr) ? rf_q[addr[AddrW-1:0]] : '0;
  endfunction

`ifdef IBEX_RF_BYPASS_EN
  // wr_commit already excludes x0 and illegal addresses, so neither can be
  // forwarded.
  assign rdata_a_o = (wr_commit && (raddr_a_i == waddr_a_i)) ? wdata_a_i
                                                             : rd_stored(raddr_a_i);
  assign rdata_b_o = (wr_commit && (raddr_b_i == waddr_a_i)) ? wdata_a_i
                                                             : rd_stored(raddr_b_i);
`else
  assign rdata_a_o = rd_stored(raddr_a_i);
  assign rdata_b_o = rd_stored(raddr_b_i);
`endif

  assign illegal_we_o = illegal_q;
  assign wr_count_o   = wr_count_q;

`ifndef SYNTHESIS
  // The WB stage must never present an unknown enable, or an unknown
  // address or data with the enable asserted.
  we_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(we_a_i) && (we_a_i -> !$isunknown({waddr_a_i, wdata_a_i})));
`endif

endmodule

// File: tb/tb_ibex_register_file_wb.sv
module tb_ibex_register_file_wb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni;
  logic [4:0]  raddr_a, raddr_b, waddr;
  logic [31:0] wdata;
  logic        we, err_clr;

  logic [31:0] rda_i, rdb_i, rda_e, rdb_e;
  logic        ill_i, ill_e;
  logic [15:0] cnt_i, cnt_e;

  ibex_register_file_wb #(.RV32E(1'b0), .DataWidth(32)) u_dut_i (
    .clk_i(clk), .rst_ni(rst_ni),
    .raddr_a_i(raddr_a), .rdata_a_o(rda_i),
    .raddr_b_i(raddr_b), .rdata_b_o(rdb_i),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .err_clr_i(err_clr), .illegal_we_o(ill_i), .wr_count_o(cnt_i)
  );

  ibex_register_file_wb #(.RV32E(1'b1), .DataWidth(32)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_ni),
    .raddr_a_i(raddr_a), .rdata_a_o(rda_e),
    .raddr_b_i(raddr_b), .rdata_b_o(rdb_e),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .err_clr_i(err_clr), .illegal_we_o(ill_e), .wr_count_o(cnt_e)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = RV32I instance, 1 = RV32E instance.
  logic [31:0] mem [2][32];
  bit          ill [2];
  int          cnt [2];

  function automatic bit implemented(int e, logic [4:0] a);
    return !(e == 1 && a >= 5'd16);
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 2; e++) begin
      for (int r = 0; r < 32; r++) mem[e][r] = '0;
      ill[e] = 1'b0;
      cnt[e] = 0;
    end
  endtask

  function automatic logic [31:0] exp_rd(int e, logic [4:0] a);
    if (!implemented(e, a) || a == 5'd0) return '0;
`ifdef IBEX_RF_BYPASS_EN
    if (we && a == waddr && implemented(e, waddr)) return wdata;
`endif
    return mem[e][a];
  endfunction

  task automatic model_update();
    for (int e = 0; e < 2; e++) begin
      bit bad;
      bad = we && !implemented(e, waddr);
      if (we && !bad && waddr != 5'd0) begin
        mem[e][waddr] = wdata;
        if (cnt[e] < 65535) cnt[e] = cnt[e] + 1;
      end
      if (bad) ill[e] = 1'b1;
      else if (err_clr) ill[e] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("rdata_a rv32i", rda_i, exp_rd(0, raddr_a));
    check("rdata_b rv32i", rdb_i, exp_rd(0, raddr_b));
    check("rdata_a rv32e", rda_e, exp_rd(1, raddr_a));
    check("rdata_b rv32e", rdb_e, exp_rd(1, raddr_b));
    check("illegal rv32i", {31'b0, ill_i}, {31'b0, ill[0]});
    check("illegal rv32e", {31'b0, ill_e}, {31'b0, ill[1]});
    check("count rv32i", {16'b0, cnt_i}, 32'(cnt[0]));
    check("count rv32e", {16'b0, cnt_e}, 32'(cnt[1]));
  endtask

  // Drive one cycle of inputs after the falling edge, optionally compare the
  // combinational/registered outputs, then advance the model at the rising edge.
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic clr, input bit do_check);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; err_clr = clr;
    #1;
    if (do_check) check_outputs();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    logic [31:0] exp_byp;
    rst_ni = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Reset contents on every address, both ports.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 1'b1);
      check("reset rdata_a const", rda_i, 32'd0);
    end
    check("reset illegal const", {31'b0, ill_e}, 32'd0);
    check("reset count const", {16'b0, cnt_i}, 32'd0);

    // x5 write then read on both ports.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 1'b1);
    check("x5 port a const", rda_i, 32'hDEADBEEF);
    check("x5 port b const", rdb_i, 32'hDEADBEEF);
    check("x5 count const", {16'b0, cnt_i}, 32'd1);

    // x0 write is ignored.
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("x0 read const", rda_i, 32'd0);
    check("x0 count const", {16'b0, cnt_i}, 32'd1);
    check("x0 illegal const", {31'b0, ill_i}, 32'd0);

    // Illegal write on the RV32E instance, clear, and set-beats-clear.
    cycle(1'b1, 5'd20, 32'h1, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 5'd20, 5'd20, 1'b0, 1'b1);
    check("x20 illegal const", {31'b0, ill_e}, 32'd1);
    check("x20 rv32e read const", rda_e, 32'd0);
    check("x20 rv32i read const", rda_i, 32'd1);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("clear illegal const", {31'b0, ill_e}, 32'd0);
    cycle(1'b1, 5'd20, 32'h1, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("set beats clear const", {31'b0, ill_e}, 32'd1);

    // Same-cycle write and read of x7.
    cycle(1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 1'b0, 1'b1);
`ifdef IBEX_RF_BYPASS_EN
    exp_byp = 32'hA5A5A5A5;
`else
    exp_byp = 32'h1;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7; raddr_b = 5'd7; err_clr = 1'b0;
    #1;
    check("x7 same-cycle a const", rda_i, exp_byp);
    check("x7 same-cycle b rv32e const", rdb_e, exp_byp);
    check_outputs();
    @(posedge clk);
    model_update();
    cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 1'b1);
    check("x7 after const", rda_i, 32'hA5A5A5A5);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) == 0), 1'b1);
    end

    // Saturate the write counter.
    for (int n = 0; n < 65536; n++) begin
      cycle(1'b1, 5'd1, $urandom, 5'd1, 5'd2, 1'b0, 1'b0);
    end
    cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b0, 1'b1);
    check("saturate rv32i const", {16'b0, cnt_i}, 32'h0000FFFF);
    check("saturate rv32e const", {16'b0, cnt_e}, 32'h0000FFFF);

    // Reset asserted while a write to x1 is pending; the write is lost.
    @(negedge clk);
    we = 1'b1; waddr = 5'd1; wdata = 32'hCAFEF00D; raddr_a = 5'd1; raddr_b = 5'd1; err_clr = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    we = 1'b0;
    #1;
    check_outputs();
    check("async reset x1 const", rda_i, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 1'b0, 1'b1);
    check("post reset x1 const", rda_i, 32'd0);
    check("post reset count const", {16'b0, cnt_i}, 32'd0);
    check("post reset illegal const", {31'b0, ill_e}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
